// File: rtl/counter_pkg.sv
// Shared encodings for the programmable counter: count modes and halt FSM states.
package counter_pkg;

   // Terminal-count behaviour selected by the mode input
   localparam logic [1:0] MODE_WRAP    = 2'd0;
   localparam logic [1:0] MODE_SAT     = 2'd1;
   localparam logic [1:0] MODE_RELOAD  = 2'd2;
   localparam logic [1:0] MODE_ONESHOT = 2'd3;

   // One-shot halt FSM state encoding
   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_HALT = 1'b1;

endpackage

// File: rtl/bus_driver.sv
// Tri-state output driver: passes the bus through when oe=1, floats it otherwise.
module bus_driver #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             oe,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out
);

   assign out = oe ? in : {WIDTH{1'bz}};

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter with wrap, saturate, auto-reload and one-shot
// terminal behaviours, cascadable through co/cin, with a tri-state count output.
module prog_counter
   import counter_pkg::*;
#(
   parameter int unsigned      WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             cin,
   input  logic             down,
   input  logic [1:0]       mode,
   input  logic             set,
   input  logic [WIDTH-1:0] in,
   input  logic             oe,
   output logic [WIDTH-1:0] out,
   output logic             co,
   output logic             tc,
   output logic             halted
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic [0:0]       state_q, state_d;
   logic             tc_q, tc_d;
   logic             at_term;
   logic             step;

   assign halted  = (state_q == ST_HALT);
   assign at_term = down ? (count_q == '0) : (count_q == '1);
   assign step    = en & cin & ~halted;
   assign co      = step & at_term;
   assign tc      = tc_q;

   // Next-state logic: set beats step, step beats hold
   always_comb begin
      count_d  = count_q;
      reload_d = reload_q;
      state_d  = state_q;
      tc_d     = 1'b0;
      if (set) begin
         count_d  = in;
         reload_d = in;
         state_d  = ST_RUN;
      end else if (step) begin
         if (!at_term) begin
            count_d = down ? (count_q - ONE) : (count_q + ONE);
         end else begin
            tc_d = 1'b1;
            unique case (mode)
               MODE_WRAP:    count_d = down ? '1 : '0;
               MODE_SAT:     count_d = count_q;
               MODE_RELOAD:  count_d = reload_q;
               MODE_ONESHOT: begin
                  count_d = reload_q;
                  state_d = ST_HALT;
               end
            endcase
         end
      end
   end

   // State registers with asynchronous active-high reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q  <= RESET_VAL;
         reload_q <= RESET_VAL;
         state_q  <= ST_RUN;
         tc_q     <= 1'b0;
      end else begin
         count_q  <= count_d;
         reload_q <= reload_d;
         state_q  <= state_d;
         tc_q     <= tc_d;
      end
   end

   bus_driver #(.WIDTH(WIDTH)) u_bus_driver (
      .oe  (oe),
      .in  (count_q),
      .out (out)
   );

endmodule

// File: tb/tb_prog_counter.sv
// Directed bench for prog_counter: two cascaded 8-bit instances; the low one
// carries most of the directed sequences, the pair together covers cascading.
module tb_prog_counter;

   logic       clk = 1'b0;
   logic       reset;
   logic       en, down, set, oe;
   logic [1:0] mode;
   logic [7:0] in;
   logic       down_hi, set_hi, oe_hi;
   logic [1:0] mode_hi;
   logic [7:0] in_hi;
   wire  [7:0] out_lo, out_hi;
   wire        co_lo, co_hi, tc_lo, tc_hi, halted_lo, halted_hi;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   prog_counter #(.WIDTH(8), .RESET_VAL(8'h00)) u_lo (
      .clk(clk), .reset(reset), .en(en), .cin(1'b1), .down(down), .mode(mode),
      .set(set), .in(in), .oe(oe), .out(out_lo), .co(co_lo), .tc(tc_lo),
      .halted(halted_lo)
   );

   prog_counter #(.WIDTH(8), .RESET_VAL(8'h00)) u_hi (
      .clk(clk), .reset(reset), .en(en), .cin(co_lo), .down(down_hi), .mode(mode_hi),
      .set(set_hi), .in(in_hi), .oe(oe_hi), .out(out_hi), .co(co_hi), .tc(tc_hi),
      .halted(halted_hi)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // advance one rising edge and settle 1ns past it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_lo(input string tag, input logic [7:0] c, input logic t, input logic h);
      chk({tag, ".out"}, {8'h00, out_lo}, {8'h00, c});
      chk({tag, ".tc"}, {15'h0, tc_lo}, {15'h0, t});
      chk({tag, ".halted"}, {15'h0, halted_lo}, {15'h0, h});
   endtask

   initial begin
      logic [7:0] zz;
      zz = 8'hzz;
      reset = 1'b1; en = 1'b0; down = 1'b0; set = 1'b0; oe = 1'b1; mode = 2'd0; in = 8'h00;
      down_hi = 1'b0; set_hi = 1'b0; oe_hi = 1'b1; mode_hi = 2'd0; in_hi = 8'h00;
      #2;
      chk_lo("reset", 8'h00, 1'b0, 1'b0);
      chk("reset.co", {15'h0, co_lo}, 16'h0);
      tick();
      reset = 1'b0;

      // wrap up from 0xFE
      set = 1'b1; in = 8'hFE; mode = 2'd0; down = 1'b0; en = 1'b1;
      tick();
      chk_lo("wrap.load", 8'hFE, 1'b0, 1'b0);
      chk("wrap.co_fe", {15'h0, co_lo}, 16'h0);
      set = 1'b0;
      tick();
      chk_lo("wrap.e1", 8'hFF, 1'b0, 1'b0);
      chk("wrap.co_ff", {15'h0, co_lo}, 16'h1);
      tick();
      chk_lo("wrap.e2", 8'h00, 1'b1, 1'b0);
      chk("wrap.co_00", {15'h0, co_lo}, 16'h0);
      tick();
      chk_lo("wrap.e3", 8'h01, 1'b0, 1'b0);

      // saturate down from 0x02
      set = 1'b1; in = 8'h02; mode = 2'd1; down = 1'b1;
      tick();
      chk_lo("sat.load", 8'h02, 1'b0, 1'b0);
      set = 1'b0;
      tick(); chk_lo("sat.e1", 8'h01, 1'b0, 1'b0);
      tick(); chk_lo("sat.e2", 8'h00, 1'b0, 1'b0);
      tick(); chk_lo("sat.e3", 8'h00, 1'b1, 1'b0);
      tick(); chk_lo("sat.e4", 8'h00, 1'b1, 1'b0);

      // one-shot down from 0x03
      set = 1'b1; in = 8'h03; mode = 2'd3; down = 1'b1;
      tick();
      chk_lo("os.load", 8'h03, 1'b0, 1'b0);
      set = 1'b0;
      tick(); chk_lo("os.e1", 8'h02, 1'b0, 1'b0);
      tick(); chk_lo("os.e2", 8'h01, 1'b0, 1'b0);
      tick(); chk_lo("os.e3", 8'h00, 1'b0, 1'b0);
      tick(); chk_lo("os.e4", 8'h03, 1'b1, 1'b1);
      chk("os.co_halted", {15'h0, co_lo}, 16'h0);
      tick(); chk_lo("os.hold1", 8'h03, 1'b0, 1'b1);
      mode = 2'd0;
      tick(); chk_lo("os.hold_mode0", 8'h03, 1'b0, 1'b1);
      set = 1'b1; in = 8'h05;
      tick(); chk_lo("os.reset_by_set", 8'h05, 1'b0, 1'b0);
      set = 1'b0;
      tick(); chk_lo("os.resume", 8'h04, 1'b0, 1'b0);

      // auto-reload up from 0xFD
      set = 1'b1; in = 8'hFD; mode = 2'd2; down = 1'b0;
      tick();
      chk_lo("rl.load", 8'hFD, 1'b0, 1'b0);
      set = 1'b0;
      tick(); chk_lo("rl.e1", 8'hFE, 1'b0, 1'b0);
      tick(); chk_lo("rl.e2", 8'hFF, 1'b0, 1'b0);
      tick(); chk_lo("rl.e3", 8'hFD, 1'b1, 1'b0);
      tick(); chk_lo("rl.e4", 8'hFE, 1'b0, 1'b0);
      tick(); chk_lo("rl.e5", 8'hFF, 1'b0, 1'b0);
      tick(); chk_lo("rl.e6", 8'hFD, 1'b1, 1'b0);

      // en low holds
      en = 1'b0;
      tick(); chk_lo("hold.en0", 8'hFD, 1'b0, 1'b0);
      en = 1'b1;

      // cascade: both at 0xFF, one step carries through
      set = 1'b1; in = 8'hFF; set_hi = 1'b1; in_hi = 8'hFF; mode = 2'd0; down = 1'b0;
      mode_hi = 2'd0; down_hi = 1'b0;
      tick();
      chk("casc.load", {out_hi, out_lo}, 16'hFFFF);
      chk("casc.co_lo", {15'h0, co_lo}, 16'h1);
      chk("casc.co_hi", {15'h0, co_hi}, 16'h1);
      set = 1'b0; set_hi = 1'b0;
      tick();
      chk("casc.step", {out_hi, out_lo}, 16'h0000);
      chk("casc.tc", {14'h0, tc_hi, tc_lo}, 16'h0003);
      oe = 1'b0; oe_hi = 1'b0;
      #1;
      chk("casc.z_lo", {8'h00, out_lo}, {8'h00, zz});
      chk("casc.z_hi", {8'h00, out_hi}, {8'h00, zz});
      oe = 1'b1; oe_hi = 1'b1;
      #1;
      chk("casc.oe_back", {out_hi, out_lo}, 16'h0000);
      en = 1'b0;
      tick();

      // reach count 0x40 in HALT, then async reset between edges
      set = 1'b1; in = 8'h40; mode = 2'd3; down = 1'b1; en = 1'b1;
      tick();
      set = 1'b0;
      for (int i = 0; i < 64; i++) tick();
      chk_lo("ar.at_zero", 8'h00, 1'b0, 1'b0);
      tick();
      chk_lo("ar.halted", 8'h40, 1'b1, 1'b1);
      #1;
      reset = 1'b1;
      #1;
      chk_lo("ar.async", 8'h00, 1'b0, 1'b0);
      set = 1'b1; in = 8'h77; mode = 2'd0; down = 1'b0;
      tick();
      chk_lo("ar.set_vs_reset", 8'h00, 1'b0, 1'b0);
      reset = 1'b0; set = 1'b0;
      tick();
      chk_lo("ar.resume", 8'h01, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/prog_counter.md
PROG_COUNTER -- requirements
Module: prog_counter

Interface
REQ-001 Parameter: WIDTH, 8, counter/bus width in bits (SHALL be >= 2).
REQ-002 Parameter: RESET_VAL, 0, value loaded into count and reload registers on reset.
REQ-003 Port: clk  input  1  clock; all state SHALL update on rising edge.
REQ-004 Port: reset  input  1  reset, asynchronous, active-high.
REQ-005 Port: en  input  1  count enable, level.
REQ-006 Port: cin  input  1  cascade carry-in; counting SHALL require en & cin (tie high if unused).
REQ-007 Port: down  input  1  direction (0 up, 1 down).
REQ-008 Port: mode  input  2  0 wrap, 1 saturate, 2 auto-reload, 3 one-shot.
REQ-009 Port: set  input  1  synchronous load strobe.
REQ-010 Port: in  input  WIDTH  load value for count and reload registers.
REQ-011 Port: oe  input  1  output enable for out.
REQ-012 Port: out  output  WIDTH  count value when oe=1, high-impedance when oe=0.
REQ-013 Port: co  output  1  combinational carry-out = step & at_term.
REQ-014 Port: tc  output  1  registered terminal-count pulse.
REQ-015 Port: halted  output  1  one-shot halt status.

Function
REQ-016 at_term SHALL be (count == all-ones) when down=0 and (count == 0) when down=1.
REQ-017 step SHALL be en & cin & ~halted.
REQ-018 Priority each edge SHALL be: set > step > hold.
REQ-019 set SHALL load count <= in and reload <= in, clear halted, and force tc=0 next cycle, regardless of en/mode.
REQ-020 step with ~at_term SHALL add +1 (up) or -1 (down) modulo 2^WIDTH in every mode.
REQ-021 step with at_term, mode 0: count SHALL wrap (all-ones -> 0 up, 0 -> all-ones down).
REQ-022 step with at_term, mode 1: count SHALL hold at terminal value.
REQ-023 step with at_term, mode 2: count SHALL load reload register.
REQ-024 step with at_term, mode 3: count SHALL load reload register and halted SHALL go 1.
REQ-025 tc SHALL be 1 for exactly the cycle after any edge where step & at_term held, in every mode; otherwise 0.
REQ-026 In mode 1, tc SHALL pulse on each stepping edge while saturated (continuous if en held).
REQ-027 halted SHALL be a two-state FSM (RUN, HALT): RUN->HALT on REQ-024 edge; HALT->RUN only on set or reset; HALT SHALL block counting and tc.
REQ-028 Changing mode or down mid-count SHALL take effect on the next edge without other side effects; halted SHALL persist until set/reset even if mode leaves 3.
REQ-029 co SHALL have no register; chained instances (co -> next cin, common clk/en) SHALL form a WIDTH*N-bit counter.
REQ-030 oe SHALL affect only the out driver, never internal state.

Reset
REQ-031 reset=1 SHALL immediately set count=RESET_VAL, reload=RESET_VAL, tc=0, halted=0 (RUN), independent of clk.
REQ-032 reset asserted mid-count or in HALT SHALL override set and step; counting SHALL resume on the first edge after reset deasserts.

Structure
REQ-033 Mode encodings (MODE_WRAP, MODE_SAT, MODE_RELOAD, MODE_ONESHOT) and FSM state encoding SHALL live in shared package counter_pkg.
REQ-034 The output driver SHALL be a WIDTH-parametrised sub-module bus_driver (oe, in, out); all other logic SHALL live in prog_counter.

Verification (WIDTH=8)
REQ-035 Wrap: set in=0xFE, mode 0, up, en=1 for 3 edges -> out 0xFF, 0x00, 0x01; tc high only in cycle after 0xFF->0x00; co high while count=0xFF.
REQ-036 Saturate down: set 0x02, mode 1, down, 4 edges -> 0x01, 0x00, 0x00, 0x00; tc high after 3rd and 4th edges.
REQ-037 One-shot: set 0x03, mode 3, down, en=1 -> 0x02, 0x01, 0x00, 0x03, then holds 0x03 with halted=1, tc single pulse; set 0x05 -> halted=0, counting resumes.
REQ-038 Auto-reload: set 0xFD, mode 2, up, 6 edges -> 0xFE, 0xFF, 0xFD, 0xFE, 0xFF, 0xFD; tc pulses twice.
REQ-039 Cascade: two instances, low co -> high cin, set both 0xFF, step once -> {high,low}=0x0000 with wrap; then oe=0 -> both out high-Z.
REQ-040 Async reset: assert reset between edges while count=0x40, halted=1 -> out=0x00, halted=0, tc=0 before next edge; set and reset same edge -> reset wins.
